// File: rtl/regfile_wb_arbiter.sv
// Write-port arbiter for the single-write-port regfile, with load-destination scoreboard.
// Optional busy-mask scoreboard is built when REGFILE_WB_SCOREBOARD_EN is defined.
module regfile_wb_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        a_valid_i,
    input  logic [4:0]  a_addr_i,
    input  logic [31:0] a_data_i,
    output logic        a_ready_o,
    input  logic        b_valid_i,
    input  logic [4:0]  b_addr_i,
    input  logic [31:0] b_data_i,
    output logic        b_ready_o,
    input  logic        issue_valid_i,
    input  logic [4:0]  issue_addr_i,
    input  logic [4:0]  read_addr_0_i,
    input  logic [4:0]  read_addr_1_i,
    output logic        hazard_0_o,
    output logic        hazard_1_o,
    output logic        wen_o,
    output logic [4:0]  write_addr_o,
    output logic [31:0] write_data_o
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] starve_q, starve_d;
    logic             wen_q, wen_d;
    logic [4:0]       write_addr_q, write_addr_d;
    logic [31:0]      write_data_q, write_data_d;
    logic             a_grant, b_grant;
    logic [31:0]      busy_w;

    // Loads win ties unless A has been denied STARVE_LIMIT cycles in a row.
    always_comb begin
        a_grant = a_valid_i && (!b_valid_i || (starve_q == LIMIT));
        b_grant = b_valid_i && !a_grant;
    end

    assign a_ready_o = a_grant && !reset_i;
    assign b_ready_o = b_grant && !reset_i;

    always_comb begin
        starve_d     = starve_q;
        wen_d        = 1'b0;
        write_addr_d = write_addr_q;
        write_data_d = write_data_q;
        if (!a_valid_i || a_grant) begin
            starve_d = '0;
        end else if (starve_q != LIMIT) begin
            starve_d = starve_q + 1'b1;
        end
        if (a_grant) begin
            wen_d        = (a_addr_i != 5'd0);
            write_addr_d = a_addr_i;
            write_data_d = a_data_i;
        end else if (b_grant) begin
            wen_d        = (b_addr_i != 5'd0);
            write_addr_d = b_addr_i;
            write_data_d = b_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            starve_q     <= '0;
            wen_q        <= 1'b0;
            write_addr_q <= '0;
            write_data_q <= '0;
        end else begin
            starve_q     <= starve_d;
            wen_q        <= wen_d;
            write_addr_q <= write_addr_d;
            write_data_q <= write_data_d;
        end
    end

`ifdef REGFILE_WB_SCOREBOARD_EN
    logic [31:0] busy_q, busy_d;

    // Set is applied after clear so a same-cycle issue to the returning address wins.
    always_comb begin
        busy_d = busy_q;
        if (b_grant) begin
            busy_d[b_addr_i] = 1'b0;
        end
        if (issue_valid_i && (issue_addr_i != 5'd0)) begin
            busy_d[issue_addr_i] = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_w = busy_q;
`else
    logic unused_issue;
    assign unused_issue = ^{issue_valid_i, issue_addr_i};
    assign busy_w       = '0;
`endif

    // The write on the port commits at end of cycle, so a matching read still sees stale data.
    assign hazard_0_o = (read_addr_0_i != 5'd0) &&
                        (busy_w[read_addr_0_i] || (wen_q && (write_addr_q == read_addr_0_i)));
    assign hazard_1_o = (read_addr_1_i != 5'd0) &&
                        (busy_w[read_addr_1_i] || (wen_q && (write_addr_q == read_addr_1_i)));

    assign wen_o        = wen_q;
    assign write_addr_o = write_addr_q;
    assign write_data_o = write_data_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter; expectations follow the scoreboard macro setting.
module tb_regfile_wb_arbiter;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        a_valid_i, b_valid_i, issue_valid_i;
    logic [4:0]  a_addr_i, b_addr_i, issue_addr_i, read_addr_0_i, read_addr_1_i;
    logic [31:0] a_data_i, b_data_i;
    logic        a_ready_o, b_ready_o, hazard_0_o, hazard_1_o, wen_o;
    logic [4:0]  write_addr_o;
    logic [31:0] write_data_o;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef REGFILE_WB_SCOREBOARD_EN
    localparam logic SB = 1'b1;
`else
    localparam logic SB = 1'b0;
`endif

    regfile_wb_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .a_valid_i(a_valid_i), .a_addr_i(a_addr_i), .a_data_i(a_data_i), .a_ready_o(a_ready_o),
        .b_valid_i(b_valid_i), .b_addr_i(b_addr_i), .b_data_i(b_data_i), .b_ready_o(b_ready_o),
        .issue_valid_i(issue_valid_i), .issue_addr_i(issue_addr_i),
        .read_addr_0_i(read_addr_0_i), .read_addr_1_i(read_addr_1_i),
        .hazard_0_o(hazard_0_o), .hazard_1_o(hazard_1_o),
        .wen_o(wen_o), .write_addr_o(write_addr_o), .write_data_o(write_data_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        reset_i = 1'b1;
        a_valid_i = 1'b1; a_addr_i = 5'd1; a_data_i = 32'h1;
        b_valid_i = 1'b1; b_addr_i = 5'd2; b_data_i = 32'h2;
        issue_valid_i = 1'b0; issue_addr_i = 5'd0;
        read_addr_0_i = 5'd0; read_addr_1_i = 5'd0;
        settle();
        chk("rst_a_ready", a_ready_o, 0);
        chk("rst_b_ready", b_ready_o, 0);
        tick();
        tick();
        chk("rst_a_ready2", a_ready_o, 0);
        chk("rst_b_ready2", b_ready_o, 0);
        chk("rst_wen", wen_o, 0);
        chk("rst_waddr", write_addr_o, 0);
        chk("rst_wdata", write_data_o, 0);

        // idle after reset
        reset_i = 1'b0; a_valid_i = 1'b0; b_valid_i = 1'b0;
        read_addr_0_i = 5'd5; read_addr_1_i = 5'd9;
        settle();
        chk("idle_haz0", hazard_0_o, 0);
        chk("idle_haz1", hazard_1_o, 0);
        chk("idle_a_ready", a_ready_o, 0);

        // single A write
        a_valid_i = 1'b1; a_addr_i = 5'd5; a_data_i = 32'hDEADBEEF;
        settle();
        chk("a1_a_ready", a_ready_o, 1);
        chk("a1_b_ready", b_ready_o, 0);
        tick();
        a_valid_i = 1'b0;
        settle();
        chk("a1_wen", wen_o, 1);
        chk("a1_waddr", write_addr_o, 5);
        chk("a1_wdata", write_data_o, 32'hDEADBEEF);
        chk("a1_haz0", hazard_0_o, 1);
        chk("a1_haz1", hazard_1_o, 0);
        tick();
        settle();
        chk("a1_wen_off", wen_o, 0);
        chk("a1_waddr_hold", write_addr_o, 5);
        chk("a1_wdata_hold", write_data_o, 32'hDEADBEEF);
        chk("a1_haz0_off", hazard_0_o, 0);

        // starvation: B B B B A, repeating
        a_valid_i = 1'b1; a_addr_i = 5'd3; a_data_i = 32'hAAAA0003;
        b_valid_i = 1'b1; b_addr_i = 5'd4; b_data_i = 32'hBBBB0004;
        for (int i = 0; i < 11; i++) begin
            settle();
            chk($sformatf("starve_a_ready_%0d", i), a_ready_o, (i % 5 == 4) ? 1 : 0);
            chk($sformatf("starve_b_ready_%0d", i), b_ready_o, (i % 5 == 4) ? 0 : 1);
            if (i > 0) begin
                chk($sformatf("starve_waddr_%0d", i), write_addr_o, ((i - 1) % 5 == 4) ? 3 : 4);
                chk($sformatf("starve_wen_%0d", i), wen_o, 1);
            end
            tick();
        end
        a_valid_i = 1'b0; b_valid_i = 1'b0;
        settle();
        chk("starve_last_wdata", write_data_o, 32'hBBBB0004);
        tick();

        // only B valid after A was starved
        b_valid_i = 1'b1; b_addr_i = 5'd0; b_data_i = 32'h1234;
        settle();
        chk("r0_b_ready", b_ready_o, 1);
        chk("r0_a_ready", a_ready_o, 0);
        tick();
        b_valid_i = 1'b0;
        settle();
        chk("r0_wen", wen_o, 0);
        read_addr_0_i = 5'd0;
        settle();
        chk("r0_haz0", hazard_0_o, 0);
        tick();

        // scoreboard on address 9
        issue_valid_i = 1'b1; issue_addr_i = 5'd9; read_addr_1_i = 5'd0;
        tick();
        issue_valid_i = 1'b0; read_addr_1_i = 5'd9;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk($sformatf("sb9_haz1_%0d", i), hazard_1_o, SB);
            tick();
        end
        b_valid_i = 1'b1; b_addr_i = 5'd9; b_data_i = 32'h99;
        settle();
        chk("sb9_b_ready", b_ready_o, 1);
        chk("sb9_haz1_M", hazard_1_o, SB);
        tick();
        b_valid_i = 1'b0;
        settle();
        chk("sb9_haz1_M1", hazard_1_o, 1);
        chk("sb9_wdata", write_data_o, 32'h99);
        tick();
        settle();
        chk("sb9_haz1_M2", hazard_1_o, 0);

        // simultaneous set and clear on address 7
        read_addr_0_i = 5'd7; read_addr_1_i = 5'd0;
        b_valid_i = 1'b1; b_addr_i = 5'd7; b_data_i = 32'h77;
        issue_valid_i = 1'b1; issue_addr_i = 5'd7;
        settle();
        chk("sc7_b_ready", b_ready_o, 1);
        chk("sc7_haz0_pre", hazard_0_o, 0);
        tick();
        b_valid_i = 1'b0; issue_valid_i = 1'b0;
        settle();
        chk("sc7_haz0_wen", hazard_0_o, 1);
        tick();
        settle();
        chk("sc7_haz0_busy1", hazard_0_o, SB);
        tick();
        settle();
        chk("sc7_haz0_busy2", hazard_0_o, SB);
        b_valid_i = 1'b1; b_data_i = 32'h770;
        settle();
        chk("sc7_b_ready2", b_ready_o, 1);
        tick();
        b_valid_i = 1'b0;
        settle();
        chk("sc7_haz0_wen2", hazard_0_o, 1);
        tick();
        settle();
        chk("sc7_haz0_clear", hazard_0_o, 0);

        // reset mid-operation drops the in-flight write and the busy bits
        a_valid_i = 1'b1; a_addr_i = 5'd12; a_data_i = 32'hC0FFEE;
        issue_valid_i = 1'b1; issue_addr_i = 5'd13;
        read_addr_0_i = 5'd12; read_addr_1_i = 5'd13;
        settle();
        chk("mr_a_ready", a_ready_o, 1);
        tick();
        a_valid_i = 1'b0; issue_valid_i = 1'b0;
        settle();
        chk("mr_wen_pre", wen_o, 1);
        chk("mr_haz1_pre", hazard_1_o, SB);
        reset_i = 1'b1; a_valid_i = 1'b1;
        settle();
        chk("mr_a_ready_rst", a_ready_o, 0);
        tick();
        reset_i = 1'b0; a_valid_i = 1'b0;
        settle();
        chk("mr_wen", wen_o, 0);
        chk("mr_waddr", write_addr_o, 0);
        chk("mr_haz0", hazard_0_o, 0);
        chk("mr_haz1", hazard_1_o, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
